pcpi_hub: RTL and testbench

- Sits between the PicoRV32 core's PCPI master port and NUM_CP coprocessors (mul, div, crypto helpers).
- Registers each core request once and broadcasts it to all coprocessors.
- Tracks claim (`wait`) and completion (`ready`), then returns a single registered response to the core.
- Raises `core_pcpi_illegal` when no coprocessor claims the instruction within TIMEOUT_CYC cycles.

---
 rtl/pcpi_hub.sv | 175 +++++++++++++++++
 tb/tb_pcpi_hub.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_hub.sv
// PCPI fan-out hub: one registered core request broadcast to NUM_CP coprocessors.
// Optional PCPI_HUB_CONFLICT_EN adds a sticky conflict_err on multiple claims/completions.
module pcpi_hub #(
    parameter int NUM_CP      = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 core_pcpi_valid,
    input  logic [31:0]          core_pcpi_insn,
    input  logic [31:0]          core_pcpi_rs1,
    input  logic [31:0]          core_pcpi_rs2,
    output logic                 core_pcpi_wr,
    output logic [31:0]          core_pcpi_rd,
    output logic                 core_pcpi_wait,
    output logic                 core_pcpi_ready,
    output logic                 core_pcpi_illegal,
`ifdef PCPI_HUB_CONFLICT_EN
    output logic                 conflict_err,
`endif
    output logic [NUM_CP-1:0]    cp_valid,
    output logic [31:0]          cp_insn,
    output logic [31:0]          cp_rs1,
    output logic [31:0]          cp_rs2,
    input  logic [NUM_CP-1:0]    cp_wr,
    input  logic [32*NUM_CP-1:0] cp_rd,
    input  logic [NUM_CP-1:0]    cp_wait,
    input  logic [NUM_CP-1:0]    cp_ready
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [NUM_CP-1:0]  r_cp_valid;
    logic [31:0]        r_insn;
    logic [31:0]        r_rs1;
    logic [31:0]        r_rs2;
    logic [31:0]        r_rd;
    logic               r_wr;
    logic               r_wait;
    logic               r_ready;
    logic               r_illegal;

    logic               w_any_ready;
    logic               w_any_wait;
    logic [31:0]        w_rd;
    logic               w_wr;

    assign w_any_ready = |cp_ready;
    assign w_any_wait  = |cp_wait;

    // Scan high to low so the lowest ready index wins.
    always_comb begin
        w_rd = '0;
        w_wr = 1'b0;
        for (int i = NUM_CP - 1; i >= 0; i--) begin
            if (cp_ready[i]) begin
                w_rd = cp_rd[32*i +: 32];
                w_wr = cp_wr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cp_valid <= '0;
            r_insn     <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_wr       <= 1'b0;
            r_wait     <= 1'b0;
            r_ready    <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_ready   <= 1'b0;
            r_illegal <= 1'b0;
            r_wr      <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (core_pcpi_valid) begin
                        r_insn     <= core_pcpi_insn;
                        r_rs1      <= core_pcpi_rs1;
                        r_rs2      <= core_pcpi_rs2;
                        r_cp_valid <= '1;
                        r_cnt      <= '0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (!core_pcpi_valid) begin
                        r_cp_valid <= '0;
                        r_wait     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_any_ready) begin
                        r_rd       <= w_rd;
                        r_wr       <= w_wr;
                        r_ready    <= 1'b1;
                        r_cp_valid <= '0;
                        r_wait     <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (r_state == S_ISSUE) begin
                        if (w_any_wait) begin
                            r_cnt   <= '0;
                            r_wait  <= 1'b1;
                            r_state <= S_WAIT;
                        end else if (r_cnt == LAST_CNT) begin
                            r_illegal  <= 1'b1;
                            r_cp_valid <= '0;
                            r_wait     <= 1'b0;
                            r_state    <= S_DONE;
                        end else begin
                            r_wait <= 1'b0;
                            r_cnt  <= r_cnt + CW'(1);
                        end
                    end else if (!w_any_wait) begin
                        r_cnt   <= '0;
                        r_wait  <= 1'b0;
                        r_state <= S_ISSUE;
                    end else begin
                        r_wait <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Wait for the core to drop valid so the same op is not re-issued.
                    if (!core_pcpi_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PCPI_HUB_CONFLICT_EN
    logic              r_conflict;
    logic [NUM_CP-1:0] w_wait_m1;
    logic [NUM_CP-1:0] w_ready_m1;
    logic              w_multi;
    logic              w_busy;

    assign w_wait_m1  = cp_wait - NUM_CP'(1);
    assign w_ready_m1 = cp_ready - NUM_CP'(1);
    assign w_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_multi    = ((cp_wait & w_wait_m1) != '0) ||
                        ((cp_ready & w_ready_m1) != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_conflict <= 1'b0;
        end else if (w_busy && w_multi) begin
            r_conflict <= 1'b1;
        end
    end

    assign conflict_err = r_conflict;
`endif

    assign core_pcpi_wr      = r_wr;
    assign core_pcpi_rd      = r_rd;
    assign core_pcpi_wait    = r_wait;
    assign core_pcpi_ready   = r_ready;
    assign core_pcpi_illegal = r_illegal;
    assign cp_valid          = r_cp_valid;
    assign cp_insn           = r_insn;
    assign cp_rs1            = r_rs1;
    assign cp_rs2            = r_rs2;

endmodule

// File: tb/tb_pcpi_hub.sv
// Directed plus randomized bench for pcpi_hub; the bench plays the coprocessors
// and predicts M-extension results arithmetically.
module tb_pcpi_hub;

    localparam int NCP = 2;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              core_pcpi_valid = 1'b0;
    logic [31:0]       core_pcpi_insn = '0;
    logic [31:0]       core_pcpi_rs1 = '0;
    logic [31:0]       core_pcpi_rs2 = '0;
    logic              core_pcpi_wr;
    logic [31:0]       core_pcpi_rd;
    logic              core_pcpi_wait;
    logic              core_pcpi_ready;
    logic              core_pcpi_illegal;
    logic [NCP-1:0]    cp_valid;
    logic [31:0]       cp_insn;
    logic [31:0]       cp_rs1;
    logic [31:0]       cp_rs2;
    logic [NCP-1:0]    cp_wr = '0;
    logic [32*NCP-1:0] cp_rd = '0;
    logic [NCP-1:0]    cp_wait = '0;
    logic [NCP-1:0]    cp_ready = '0;
`ifdef PCPI_HUB_CONFLICT_EN
    logic              conflict_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcpi_hub #(.NUM_CP(NCP), .TIMEOUT_CYC(TO)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .core_pcpi_valid   (core_pcpi_valid),
        .core_pcpi_insn    (core_pcpi_insn),
        .core_pcpi_rs1     (core_pcpi_rs1),
        .core_pcpi_rs2     (core_pcpi_rs2),
        .core_pcpi_wr      (core_pcpi_wr),
        .core_pcpi_rd      (core_pcpi_rd),
        .core_pcpi_wait    (core_pcpi_wait),
        .core_pcpi_ready   (core_pcpi_ready),
        .core_pcpi_illegal (core_pcpi_illegal),
`ifdef PCPI_HUB_CONFLICT_EN
        .conflict_err      (conflict_err),
`endif
        .cp_valid          (cp_valid),
        .cp_insn           (cp_insn),
        .cp_rs1            (cp_rs1),
        .cp_rs2            (cp_rs2),
        .cp_wr             (cp_wr),
        .cp_rd             (cp_rd),
        .cp_wait           (cp_wait),
        .cp_ready          (cp_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_insn(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Reference M-extension results (divisor never zero, no overflow case).
    function automatic logic [31:0] ref_m(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (f3)
            3'd4:    return $signed(a) / $signed(b);
            3'd5:    return a / b;
            3'd6:    return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr"}, 32'(core_pcpi_wr), 32'd0);
        chk({tag, "_rd"}, core_pcpi_rd, 32'd0);
        chk({tag, "_wait"}, 32'(core_pcpi_wait), 32'd0);
        chk({tag, "_ready"}, 32'(core_pcpi_ready), 32'd0);
        chk({tag, "_illegal"}, 32'(core_pcpi_illegal), 32'd0);
        chk({tag, "_cpvalid"}, 32'(cp_valid), 32'd0);
        chk({tag, "_insn"}, cp_insn, 32'd0);
        chk({tag, "_rs1"}, cp_rs1, 32'd0);
        chk({tag, "_rs2"}, cp_rs2, 32'd0);
    endtask

    // One full transaction with coprocessor idx answering after lat cycles.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int idx,
                          input logic claim, input int lat,
                          output logic [31:0] rd_obs);
        logic [31:0] insn;
        logic [31:0] exp;
        insn = mk_insn(f3);
        exp  = ref_m(f3, a, b);
        core_pcpi_valid = 1'b1;
        core_pcpi_insn  = insn;
        core_pcpi_rs1   = a;
        core_pcpi_rs2   = b;
        step();
        chk("op_cpvalid", 32'(cp_valid), 32'(2'b11));
        chk("op_insn", cp_insn, insn);
        chk("op_rs1", cp_rs1, a);
        chk("op_rs2", cp_rs2, b);
        cp_wait[idx] = claim;
        for (int k = 0; k < lat; k++) begin
            step();
            chk("op_wait", 32'(core_pcpi_wait), 32'(claim));
            chk("op_early_ready", 32'(core_pcpi_ready), 32'd0);
        end
        cp_ready[idx] = 1'b1;
        cp_wr[idx] = 1'b1;
        cp_rd[32*idx +: 32] = exp;
        step();
        rd_obs = core_pcpi_rd;
        chk("op_ready", 32'(core_pcpi_ready), 32'd1);
        chk("op_rd", core_pcpi_rd, exp);
        chk("op_wr", 32'(core_pcpi_wr), 32'd1);
        chk("op_cpvalid_drop", 32'(cp_valid), 32'd0);
        chk("op_illegal", 32'(core_pcpi_illegal), 32'd0);
        cp_ready = '0;
        cp_wait  = '0;
        cp_wr    = '0;
        cp_rd    = '0;
        step();
        chk("op_ready_once", 32'(core_pcpi_ready), 32'd0);
        step();
        chk("op_no_reissue", 32'(cp_valid), 32'd0);
        chk("op_insn_stable", cp_insn, insn);
        core_pcpi_valid = 1'b0;
        step();
        chk("op_idle_cpvalid", 32'(cp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd_obs;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        step();
        step();
        chk_all_zero("reset");
        resetn = 1'b1;
        step();

        run_op(3'd5, 32'd100, 32'd7, 1, 1'b1, 3, rd_obs);
        chk("divu_100_7", rd_obs, 32'd14);
`ifdef PCPI_HUB_CONFLICT_EN
        chk("no_conflict", 32'(conflict_err), 32'd0);
`endif

        // Unclaimed custom-0 op must time out as illegal.
        core_pcpi_valid = 1'b1;
        core_pcpi_insn  = 32'h0000000B;
        step();
        chk("ill_cpvalid", 32'(cp_valid), 32'(2'b11));
        for (int k = 1; k < TO; k++) begin
            step();
            chk("ill_early", 32'(core_pcpi_illegal), 32'd0);
        end
        step();
        chk("ill_pulse", 32'(core_pcpi_illegal), 32'd1);
        chk("ill_no_ready", 32'(core_pcpi_ready), 32'd0);
        chk("ill_cpvalid_drop", 32'(cp_valid), 32'd0);
        step();
        chk("ill_once", 32'(core_pcpi_illegal), 32'd0);
        core_pcpi_valid = 1'b0;
        step();

        // Two completions in the same cycle: index 0 wins.
        core_pcpi_valid = 1'b1;
        core_pcpi_insn  = mk_insn(3'd4);
        step();
        cp_ready = 2'b11;
        cp_wait  = 2'b11;
        cp_wr    = 2'b10;
        cp_rd    = {32'h5555FFFF, 32'hAAAA0000};
        step();
        chk("both_ready", 32'(core_pcpi_ready), 32'd1);
        chk("both_rd", core_pcpi_rd, 32'hAAAA0000);
        chk("both_wr", 32'(core_pcpi_wr), 32'd0);
        cp_ready = '0;
        cp_wait  = '0;
        cp_wr    = '0;
        cp_rd    = '0;
        core_pcpi_valid = 1'b0;
        step();
`ifdef PCPI_HUB_CONFLICT_EN
        chk("conflict_set", 32'(conflict_err), 32'd1);
`endif
        step();

        // Reset while a coprocessor has claimed the op.
        core_pcpi_valid = 1'b1;
        core_pcpi_insn  = mk_insn(3'd5);
        core_pcpi_rs1   = 32'd9;
        core_pcpi_rs2   = 32'd2;
        step();
        cp_wait = 2'b01;
        step();
        chk("rst_wait_up", 32'(core_pcpi_wait), 32'd1);
`ifdef PCPI_HUB_CONFLICT_EN
        chk("conflict_sticky", 32'(conflict_err), 32'd1);
`endif
        resetn = 1'b0;
        step();
        chk_all_zero("midrst");
`ifdef PCPI_HUB_CONFLICT_EN
        chk("conflict_clr", 32'(conflict_err), 32'd0);
`endif
        resetn = 1'b1;
        core_pcpi_valid = 1'b0;
        cp_wait = '0;
        step();
        run_op(3'd4, -32'sd20, 32'd3, 0, 1'b1, 2, rd_obs);
        chk("div_m20_3", rd_obs, 32'hFFFFFFFA);

        // Abort in WAIT, then a stale completion that must be dropped.
        core_pcpi_valid = 1'b1;
        core_pcpi_insn  = mk_insn(3'd6);
        step();
        cp_wait = 2'b10;
        step();
        chk("abort_wait", 32'(core_pcpi_wait), 32'd1);
        core_pcpi_valid = 1'b0;
        step();
        chk("abort_cpvalid", 32'(cp_valid), 32'd0);
        chk("abort_wait_drop", 32'(core_pcpi_wait), 32'd0);
        cp_wait  = '0;
        cp_ready = 2'b10;
        cp_wr    = 2'b10;
        cp_rd    = {32'd123, 32'd0};
        step();
        chk("late_no_ready", 32'(core_pcpi_ready), 32'd0);
        chk("late_no_illegal", 32'(core_pcpi_illegal), 32'd0);
        cp_ready = '0;
        cp_wr    = '0;
        cp_rd    = '0;
        step();
        chk("late_still_none", 32'(core_pcpi_ready), 32'd0);
        run_op(3'd6, 32'd17, 32'd5, 1, 1'b1, 1, rd_obs);
        chk("rem_17_5", rd_obs, 32'd2);

        for (int n = 0; n < 24; n++) begin
            f3 = 3'(4 + $urandom_range(0, 3));
            a  = $urandom;
            b  = 32'($urandom_range(1, 5000));
            if ($urandom_range(0, 1) == 1) b = -b;
            if (a == 32'h80000000) a = 32'd1;
            run_op(f3, a, b, int'($urandom_range(0, NCP - 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                   rd_obs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
